// File: rtl/erase_fill_writer.sv
// In-order writer into a DEPTH-entry store; an erasure request scrubs every
// entry to zero and guarantees no source word is written or held across it.
module erase_fill_writer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              invalid_i,
  input  logic              release_i,
  input  logic              in_valid_i,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              in_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [WIDTH-1:0]  wr_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              scrub_busy_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, FULL, SCRUB} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   scrub_ptr_q, scrub_ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic               full_q, full_d;
  logic               scrub_busy_q, scrub_busy_d;
  logic               scrub_done_c;
  logic               scrub_start_c;
  logic               accept_c;

  assign in_ready_o    = !invalid_i && !release_i && (state_q != SCRUB) && !full_q;
  assign accept_c      = in_valid_i && in_ready_o;
  // scrub_ptr_q == DEPTH means the last scrub write is on the outputs now
  assign scrub_done_c  = (state_q == SCRUB) && (scrub_ptr_q == CNT_W'(DEPTH));
  assign scrub_start_c = invalid_i && ((state_q != SCRUB) || scrub_done_c);

  // Next-state and registered-output logic; the write pointer equals count_q.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    scrub_ptr_d  = scrub_ptr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    full_d       = full_q;
    scrub_busy_d = scrub_busy_q;

    if (invalid_i) begin
      wr_data_d = '0;
    end

    if (scrub_start_c) begin
      state_d      = SCRUB;
      wr_en_d      = 1'b1;
      wr_addr_d    = '0;
      wr_data_d    = '0;
      scrub_ptr_d  = CNT_W'(1);
      scrub_busy_d = 1'b1;
      if (scrub_done_c) begin
        count_d = '0;
        full_d  = 1'b0;
      end
    end else if (scrub_done_c) begin
      state_d      = IDLE;
      count_d      = '0;
      full_d       = 1'b0;
      scrub_busy_d = 1'b0;
    end else if (state_q == SCRUB) begin
      wr_en_d     = 1'b1;
      wr_addr_d   = scrub_ptr_q[ADDR_W-1:0];
      wr_data_d   = '0;
      scrub_ptr_d = scrub_ptr_q + CNT_W'(1);
    end else if (release_i) begin
      state_d = IDLE;
      count_d = '0;
      full_d  = 1'b0;
    end else if (accept_c) begin
      wr_en_d   = 1'b1;
      wr_addr_d = count_q[ADDR_W-1:0];
      wr_data_d = in_data_i;
      count_d   = count_q + CNT_W'(1);
      full_d    = (count_d == CNT_W'(DEPTH));
      state_d   = full_d ? FULL : FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      scrub_ptr_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      full_q       <= 1'b0;
      scrub_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      scrub_ptr_q  <= scrub_ptr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      full_q       <= full_d;
      scrub_busy_q <= scrub_busy_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign count_o      = count_q;
  assign full_o       = full_q;
  assign scrub_busy_o = scrub_busy_q;

endmodule

// File: tb/tb_erase_fill_writer.sv
// Bench for erase_fill_writer: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a queue-based model.
module tb_erase_fill_writer;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 2;

  logic          clk;
  logic          rst;
  logic          inv;
  logic          rel;
  logic          vld;
  logic [W-1:0]  din;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW:0]   count;
  logic          full;
  logic          busy;

  erase_fill_writer #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .invalid_i    (inv),
    .release_i    (rel),
    .in_valid_i   (vld),
    .in_data_i    (din),
    .in_ready_o   (in_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .count_o      (count),
    .full_o       (full),
    .scrub_busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: pending scrub addresses live in a queue.
  bit        m_valid = 0;
  bit        m_busy;
  int        m_count;
  bit        m_wen;
  int        m_addr;
  logic [W-1:0] m_data;
  int        scrub_q[$];
  logic      last_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  task automatic start_scrub();
    scrub_q.delete();
    for (int a = 0; a < int'(D); a++) scrub_q.push_back(a);
    m_addr = scrub_q.pop_front();
    m_wen  = 1'b1;
    m_data = '0;
    m_busy = 1'b1;
  endtask

  task automatic model_update(input logic r, input logic i, input logic l,
                              input logic v, input logic [W-1:0] d);
    if (r) begin
      m_busy = 0; m_count = 0; m_wen = 0; m_addr = 0; m_data = '0;
      scrub_q.delete();
      m_valid = 1;
    end else if (m_busy) begin
      if (scrub_q.size() > 0) begin
        m_addr = scrub_q.pop_front();
        m_wen  = 1'b1;
        m_data = '0;
      end else begin
        m_count = 0;
        m_wen   = 1'b0;
        m_busy  = 1'b0;
        if (i) start_scrub();
      end
    end else if (i) begin
      start_scrub();
    end else if (l) begin
      m_count = 0;
      m_wen   = 1'b0;
    end else if (v && m_count < int'(D)) begin
      m_wen   = 1'b1;
      m_addr  = m_count;
      m_data  = d;
      m_count = m_count + 1;
    end else begin
      m_wen = 1'b0;
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input logic r, input logic i, input logic l,
                      input logic v, input logic [W-1:0] d);
    rst = r; inv = i; rel = l; vld = v; din = d;
    @(negedge clk);
    last_rdy = in_ready;
    if (m_valid) begin
      chk("wr_en",    32'(wr_en),    32'(m_wen));
      chk("wr_addr",  32'(wr_addr),  32'(m_addr));
      chk("wr_data",  32'(wr_data),  32'(m_data));
      chk("count",    32'(count),    32'(m_count));
      chk("full",     32'(full),     32'(m_count == int'(D)));
      chk("busy",     32'(busy),     32'(m_busy));
      chk("in_ready", 32'(in_ready),
          32'(!i && !l && !m_busy && (m_count < int'(D))));
    end
    @(posedge clk);
    model_update(r, i, l, v, d);
    #1;
  endtask

  initial begin
    rst = 1'b1; inv = 1'b0; rel = 1'b0; vld = 1'b0; din = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back fill
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 8'(17 * (k + 1)));
      chk("fill_wen",  32'(wr_en),   32'd1);
      chk("fill_addr", 32'(wr_addr), 32'(k));
      chk("fill_data", 32'(wr_data), 32'(17 * (k + 1)));
    end
    chk("full_set",     32'(full),     32'd1);
    chk("full_noready", 32'(in_ready), 32'd0);
    step(0, 0, 0, 1, 8'h55);
    chk("fifth_rdy",   32'(last_rdy), 32'd0);
    chk("fifth_wen",   32'(wr_en),    32'd0);
    chk("fifth_count", 32'(count),    32'd4);

    // Release while full, then refill from address 0
    step(0, 0, 1, 0, 0);
    chk("rel_count", 32'(count), 32'd0);
    chk("rel_wen",   32'(wr_en), 32'd0);
    chk("rel_full",  32'(full),  32'd0);
    step(0, 0, 0, 1, 8'h77);
    chk("post_rel_addr", 32'(wr_addr), 32'd0);
    chk("post_rel_data", 32'(wr_data), 32'h77);

    // Invalidate mid-fill
    step(0, 0, 0, 1, 8'hA5);
    chk("a5_addr", 32'(wr_addr), 32'd1);
    step(0, 0, 0, 1, 8'h5A);
    chk("5a_addr", 32'(wr_addr), 32'd2);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(0, 0, 0, 0, 0);
      chk("scrub_wen",  32'(wr_en),   32'd1);
      chk("scrub_addr", 32'(wr_addr), 32'(k));
      chk("scrub_data", 32'(wr_data), 32'd0);
      chk("scrub_busy", 32'(busy),    32'd1);
    end
    step(0, 0, 0, 0, 0);
    chk("scrub_end_rdy_low", 32'(last_rdy), 32'd0);
    chk("scrub_end_busy",    32'(busy),     32'd0);
    chk("scrub_end_count",   32'(count),    32'd0);
    chk("scrub_end_ready",   32'(in_ready), 32'd1);

    // Simultaneous valid and invalid
    step(0, 1, 0, 1, 8'hFF);
    chk("sim_rdy",  32'(last_rdy), 32'd0);
    chk("sim_data", 32'(wr_data),  32'd0);
    chk("sim_addr", 32'(wr_addr),  32'd0);
    chk("sim_busy", 32'(busy),     32'd1);
    repeat (4) step(0, 0, 0, 0, 0);

    // Invalid held for 6 cycles: scrub restarts at completion
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 0, 0);
      chk("held_rdy", 32'(last_rdy), 32'd0);
      if (k == 3) chk("held_last_addr", 32'(wr_addr), 32'd3);
      if (k == 4) begin
        chk("held_restart_addr", 32'(wr_addr), 32'd0);
        chk("held_restart_busy", 32'(busy),    32'd1);
      end
    end
    repeat (3) step(0, 0, 0, 0, 0);
    chk("held_done_busy", 32'(busy), 32'd0);

    // Reset during the second scrub cycle
    step(0, 0, 0, 1, 8'h12);
    step(0, 0, 0, 1, 8'h34);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mid_scrub_addr", 32'(wr_addr), 32'd1);
    step(1, 0, 0, 0, 0);
    chk("abort_wen",   32'(wr_en),   32'd0);
    chk("abort_busy",  32'(busy),    32'd0);
    chk("abort_count", 32'(count),   32'd0);
    chk("abort_addr",  32'(wr_addr), 32'd0);
    chk("abort_data",  32'(wr_data), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("no_resume_wen",  32'(wr_en), 32'd0);
    chk("no_resume_busy", 32'(busy),  32'd0);

    // Randomized traffic
    repeat (3000) begin
      step(logic'($urandom_range(0, 199) == 0),
           logic'($urandom_range(0, 99) < 7),
           logic'($urandom_range(0, 99) < 6),
           logic'($urandom_range(0, 99) < 65),
           W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/erase_fill_writer.md
# erase_fill_writer

Producer-side writer for an erasure-labelled register bank. It accepts high-confidentiality words over a valid/ready handshake and writes them in order into a DEPTH-entry downstream store. When the erasure condition `invalid` is asserted, it scrubs every entry to zero, one entry per cycle. It sits between a high-security data source and the storage/readout logic that exposes data only while `invalid` is high. It guarantees that no high value is written, staged or held across an edge where `invalid` was sampled high.

## Interface
- `WIDTH`, default 8: data word width.
- `DEPTH`, default 4: number of store entries; must be a power of 2, ≥2.
- `ADDR_W`, default 2: log2(DEPTH).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `invalid` in 1 (L): erasure request; sampled every edge.
- `release` in 1 (L): one-cycle pulse from the reader meaning "store consumed". Resets the fill position without scrubbing.
- `in_valid` in 1 (L): source presents a word.
- `in_data` in WIDTH (H): source word.
- `in_ready` out 1 (L): writer can accept (combinational).
- `wr_en` out 1 (L): registered store write strobe.
- `wr_addr` out ADDR_W (L): registered store address.
- `wr_data` out WIDTH: registered store data. Label is erase(L; epol invalid; (); H): H normally, L once erased.
- `count` out ADDR_W+1 (L): number of valid entries written.
- `full` out 1 (L): `count == DEPTH`.
- `scrub_busy` out 1 (L): scrub sequence in progress.

## Operation
- States:
  - IDLE: `count == 0`.
  - FILL: `0 < count < DEPTH`.
  - FULL.
  - SCRUB.
- `in_ready = !invalid && !release && state != SCRUB && !full`.
- Accept when `in_valid && in_ready`:
  - Next edge: `wr_en=1`, `wr_addr=wr_ptr`, `wr_data=in_data`.
  - `wr_ptr` and `count` increment.
- `wr_ptr` never wraps. It returns to 0 only on scrub completion, on `release`, or on `rst`.
- `release` (`invalid` low, not in SCRUB): next edge `count=0`, `wr_ptr=0`, state IDLE. No writes are issued.
- `release` during SCRUB is ignored.
- Edge with `invalid=1`, from any non-SCRUB state:
  - `wr_data` is cleared to 0, and `wr_en` drops unless a scrub write is issued.
  - State goes to SCRUB with `scrub_ptr=0`.
  - No staged `in_data` survives that edge.
- SCRUB:
  - Each cycle: `wr_en=1`, `wr_addr=scrub_ptr`, `wr_data=0`; `scrub_ptr` increments.
  - After entry DEPTH-1 is written: `count=0`, `wr_ptr=0`, state IDLE.
  - `invalid` during SCRUB does not restart the sequence. If `invalid` is high at the edge that completes the scrub, a new full scrub begins immediately.
- Priority: `rst` > `invalid` > `release` > accept.
- `count` saturates at DEPTH.
- Security: the only path from `in_data` to `wr_data` is gated by `!invalid` on the same edge. The checker must accept the implementation without downgrades.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `count=0`, `full=0`, `scrub_busy=0`, state IDLE. `in_ready=1` in the first cycle after reset if `invalid` and `release` are low.
- Accept-to-write latency: 1 cycle.
- Throughput: 1 word/cycle until `full`.
- Scrub timing, with `invalid` sampled at edge E:
  - Scrub writes appear in cycles E+1 through E+DEPTH, addresses 0..DEPTH-1 ascending.
  - `scrub_busy` is high for exactly those DEPTH cycles.
  - `count` reads 0 from E+DEPTH+1.
  - `in_ready` can return high in cycle E+DEPTH+1.
- `full` rises the cycle after the DEPTH-th accept. `in_ready` is low in that same cycle.
- `rst` mid-scrub aborts the scrub. Outputs take their reset values on the next edge.

## Test plan
- Fill: after reset, send 0x11, 0x22, 0x33, 0x44 back-to-back → `wr_addr` 0,1,2,3 with that data on consecutive cycles. `full=1` and `in_ready=0` after the 4th accept; a 5th `in_valid` is not accepted.
- Invalidate mid-fill: accept 0xA5 and 0x5A, then raise `invalid` for 1 cycle → next 4 cycles show `wr_en=1`, addr 0..3, `wr_data=0`, `scrub_busy=1`. Afterwards `count=0` and `in_ready=1`.
- Simultaneous `in_valid` (0xFF) and `invalid` → `in_ready=0`. 0xFF never appears on `wr_data`; the scrub starts.
- Held `invalid` for 6 cycles → first scrub completes, and a second full scrub starts immediately because `invalid` is still high at completion. `in_ready` stays low throughout.
- `release` while FULL → `count=0` next cycle with no `wr_en` pulses. The next accept of 0x77 is written at `wr_addr=0`.
- `rst` asserted during the 2nd scrub cycle → all outputs take their reset values on the next cycle and the scrub does not resume.
